seg_trace_monitor: RTL and testbench

Receiving end of the microprocessor's display outputs. It samples the four 7-segment digit buses (`AddressTens/Ones`, `InstTens/Ones`), `RawOutput` and `LED`, and decodes the glyphs back to hex nibbles. It filters out glitching during glyph transitions and queues one trace record per settled change into a FIFO, which a bench or host drains over a valid/ready port. It sits beside the CPU top on the same clock and gives regressions an execution trace without reading segment waveforms by hand.

---
 rtl/seg_trace_pkg.sv | 79 +++++++
 rtl/trace_fifo.sv | 83 ++++++++
 rtl/seg_trace_monitor.sv | 119 +++++++++++
 tb/tb_seg_trace_monitor.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_trace_pkg.sv
// Purpose: glyph constants, record layout and glyph decoder for the segment trace monitor.
// Latency: none (types, constants and a combinational function only).
// Backpressure: not applicable.
package seg_trace_pkg;

    // Active-low glyphs, bit6..0 = g,f,e,d,c,b,a (0 = segment lit)
    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

    // Trace record layout
    localparam int REC_W        = 26;
    localparam int REC_ERR_BIT  = 25;
    localparam int REC_LED_BIT  = 24;
    localparam int REC_RAW_LSB  = 16;
    localparam int REC_ADDR_LSB = 8;
    localparam int REC_INST_LSB = 0;

    // One registered snapshot of every display input (37 bits)
    typedef struct packed {
        logic [6:0] addressTens;
        logic [6:0] addressOnes;
        logic [6:0] instTens;
        logic [6:0] instOnes;
        logic [7:0] rawOutput;
        logic       led;
    } sample_t;

    // Field order matches the REC_* offsets above
    typedef struct packed {
        logic       err;
        logic       led;
        logic [7:0] rawOutput;
        logic [3:0] addrTens;
        logic [3:0] addrOnes;
        logic [3:0] instTens;
        logic [3:0] instOnes;
    } record_t;

    // Returns {err, nibble}; unknown patterns (blank included) give nibble 0 with err set
    function automatic logic [4:0] seg_decode(input logic [6:0] glyph);
        logic [4:0] res;
        res = 5'b1_0000;
        case (glyph)
            GLYPH_0: res = 5'h00;
            GLYPH_1: res = 5'h01;
            GLYPH_2: res = 5'h02;
            GLYPH_3: res = 5'h03;
            GLYPH_4: res = 5'h04;
            GLYPH_5: res = 5'h05;
            GLYPH_6: res = 5'h06;
            GLYPH_7: res = 5'h07;
            GLYPH_8: res = 5'h08;
            GLYPH_9: res = 5'h09;
            GLYPH_A: res = 5'h0A;
            GLYPH_B: res = 5'h0B;
            GLYPH_C: res = 5'h0C;
            GLYPH_D: res = 5'h0D;
            GLYPH_E: res = 5'h0E;
            GLYPH_F: res = 5'h0F;
            default: res = 5'b1_0000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Purpose: generic synchronous FIFO with occupancy and push-side drop accounting.
// Latency: a push is visible at the head one edge later; level/headVld are registered state.
// Backpressure: headVld/popRdy on the read side; a push into a full FIFO without a pop is dropped and counted.
module trace_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   Reset,
    input  logic                   pushVld,
    input  logic [WIDTH-1:0]       pushDat,
    output logic                   headVld,
    input  logic                   popRdy,
    output logic [WIDTH-1:0]       headDat,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [7:0]             dropCount
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             full;
    logic             doPop;
    logic             doPush;
    logic             doDrop;

    // Handshake decisions; a full FIFO still accepts a push when the head leaves in the same cycle
    always_comb begin
        full   = (level == FULL_LVL);
        doPop  = headVld && popRdy;
        doPush = pushVld && (!full || doPop);
        doDrop = pushVld && full && !doPop;
    end

    // Head is forced to zero when empty so the port never shows stale storage
    assign headVld = (level != '0);
    assign headDat = headVld ? mem[rdPtr] : '0;

    // Storage write; the head slot is never overwritten while it is still presented
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushDat;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (doPush && !doPop) begin
                level <= level + 1'b1;
            end else if (doPop && !doPush) begin
                level <= level - 1'b1;
            end
        end
    end

    // Sticky overflow flag and saturating drop counter
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            overflow  <= 1'b0;
            dropCount <= '0;
        end else if (doDrop) begin
            overflow <= 1'b1;
            if (dropCount != 8'hFF) begin
                dropCount <= dropCount + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_trace_monitor.sv
// Purpose: samples the CPU display buses, decodes glyphs, queues one trace record per settled change.
// Latency: STABLE_CYCLES+2 edges from an input change to rec_valid.
// Backpressure: rec_valid/rec_ready; when the FIFO is full a new record is dropped and counted, never retried.
module seg_trace_monitor
    import seg_trace_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   Reset,
    input  logic [6:0]             AddressTens,
    input  logic [6:0]             AddressOnes,
    input  logic [6:0]             InstTens,
    input  logic [6:0]             InstOnes,
    input  logic [7:0]             RawOutput,
    input  logic                   LED,
    output logic                   rec_valid,
    input  logic                   rec_ready,
    output logic [REC_W-1:0]       rec_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [7:0]             drop_count
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    sample_t          sampleNow;
    sample_t          inQ;
    logic             primed;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       decAddrTens;
    logic [4:0]       decAddrOnes;
    logic [4:0]       decInstTens;
    logic [4:0]       decInstOnes;
    record_t          candRec;
    record_t          lastRec;
    logic             lastValid;
    logic             commit;

    // Gather the raw display pins into one snapshot
    always_comb begin
        sampleNow             = '0;
        sampleNow.addressTens = AddressTens;
        sampleNow.addressOnes = AddressOnes;
        sampleNow.instTens    = InstTens;
        sampleNow.instOnes    = InstOnes;
        sampleNow.rawOutput   = RawOutput;
        sampleNow.led         = LED;
    end

    // Input register; primed marks that a real sample has been taken since reset
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            inQ    <= '0;
            primed <= 1'b0;
        end else begin
            inQ    <= sampleNow;
            primed <= 1'b1;
        end
    end

    // Stability counter: the first sample after reset counts as a change, so an all-zero
    // bus still takes the full settling time before its first record
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            cnt <= '0;
        end else if (!primed || (sampleNow != inQ)) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Decode the registered glyphs into the candidate record
    always_comb begin
        decAddrTens       = seg_decode(inQ.addressTens);
        decAddrOnes       = seg_decode(inQ.addressOnes);
        decInstTens       = seg_decode(inQ.instTens);
        decInstOnes       = seg_decode(inQ.instOnes);
        candRec           = '0;
        candRec.err       = decAddrTens[4] | decAddrOnes[4] | decInstTens[4] | decInstOnes[4];
        candRec.led       = inQ.led;
        candRec.rawOutput = inQ.rawOutput;
        candRec.addrTens  = decAddrTens[3:0];
        candRec.addrOnes  = decAddrOnes[3:0];
        candRec.instTens  = decInstTens[3:0];
        candRec.instOnes  = decInstOnes[3:0];
        commit            = (cnt == CNT_MAX) && (!lastValid || (candRec != lastRec));
    end

    // Remember the last committed value even if the FIFO drops it, so it is not offered again
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            lastRec   <= '0;
            lastValid <= 1'b0;
        end else if (commit) begin
            lastRec   <= candRec;
            lastValid <= 1'b1;
        end
    end

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .Reset     (Reset),
        .pushVld   (commit),
        .pushDat   (candRec),
        .headVld   (rec_valid),
        .popRdy    (rec_ready),
        .headDat   (rec_data),
        .level     (level),
        .overflow  (overflow),
        .dropCount (drop_count)
    );

endmodule

// File: tb/tb_seg_trace_monitor.sv
// Purpose: randomized + directed scoreboard bench for seg_trace_monitor.
// Latency: expected records are queued when the reference FIFO accepts them.
// Backpressure: rec_ready is driven by the bench, both held low and randomized.
module tb_seg_trace_monitor;
    localparam int DEPTH = 16;
    localparam int S     = 4;

    logic       clk   = 1'b0;
    logic       Reset = 1'b0;
    logic [6:0] aT = '0, aO = '0, iT = '0, iO = '0;
    logic [7:0] raw = '0;
    logic       led = 1'b0;
    logic       rdy = 1'b0;

    logic        recValid;
    logic [25:0] recData;
    logic [4:0]  level;
    logic        overflow;
    logic [7:0]  dropCount;

    int total    = 0;
    int bad      = 0;
    int popCount = 0;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 clk = ~clk;

    seg_trace_monitor #(.DEPTH(DEPTH), .STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .Reset       (Reset),
        .AddressTens (aT),
        .AddressOnes (aO),
        .InstTens    (iT),
        .InstOnes    (iO),
        .RawOutput   (raw),
        .LED         (led),
        .rec_valid   (recValid),
        .rec_ready   (rdy),
        .rec_data    (recData),
        .level       (level),
        .overflow    (overflow),
        .drop_count  (dropCount)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Glyph table lookup: index of the glyph, or error with nibble 0
    function automatic logic [4:0] refDigit(input logic [6:0] p);
        for (int k = 0; k < 16; k++) begin
            if (glyph[k] == p) return {1'b0, 4'(k)};
        end
        return 5'b1_0000;
    endfunction

    function automatic logic [25:0] refRecord(input logic [36:0] s);
        logic [4:0] d0, d1, d2, d3;
        d0 = refDigit(s[36:30]);
        d1 = refDigit(s[29:23]);
        d2 = refDigit(s[22:16]);
        d3 = refDigit(s[15:9]);
        return {d0[4] | d1[4] | d2[4] | d3[4], s[0], s[8:1], d0[3:0], d1[3:0], d2[3:0], d3[3:0]};
    endfunction

    // ---------------- reference model ----------------
    int          mLevel = 0;
    int          mDrops = 0;
    bit          mOverflow = 0;
    int          runLen = 0;
    logic [36:0] lastSample;
    logic [36:0] cur;
    bit          pending = 0;
    logic [25:0] pendRec;
    bit          haveRec = 0;
    logic [25:0] lastRecVal;
    bit          popNow;
    logic [25:0] sbq [$];

    // A value is recorded once it has been seen on S+1 consecutive edges and differs from the last one recorded
    always @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            mLevel = 0; mDrops = 0; mOverflow = 0;
            runLen = 0; pending = 0; haveRec = 0;
            sbq.delete();
        end else begin
            popNow = (mLevel > 0) && rdy;
            if (pending) begin
                if (mLevel == DEPTH && !popNow) begin
                    mOverflow = 1;
                    if (mDrops < 255) mDrops++;
                end else begin
                    sbq.push_back(pendRec);
                    mLevel++;
                end
            end
            if (popNow) mLevel--;
            pending = 0;
            cur = {aT, aO, iT, iO, raw, led};
            if (runLen > 0 && cur == lastSample) runLen++;
            else runLen = 1;
            lastSample = cur;
            if (runLen == S + 1 && (!haveRec || refRecord(cur) != lastRecVal)) begin
                pending    = 1;
                pendRec    = refRecord(cur);
                lastRecVal = pendRec;
                haveRec    = 1;
            end
        end
    end

    // ---------------- monitor ----------------
    logic [25:0] prevData;
    bit          prevStall = 0;

    always @(negedge clk) begin
        check("valid", 32'(recValid), 32'(mLevel > 0));
        check("level", 32'(level), 32'(mLevel));
        check("overflow", 32'(overflow), 32'(mOverflow));
        check("drop_count", 32'(dropCount), 32'(mDrops));
        if (!Reset) begin
            check("reset_data", 32'(recData), 32'h0);
            prevStall = 0;
        end else begin
            if (prevStall) check("stall_hold", 32'(recData), 32'(prevData));
            if (recValid && rdy) begin
                popCount++;
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_record: got %0h want none", recData);
                end else begin
                    check("record", 32'(recData), 32'(sbq.pop_front()));
                end
            end
            prevStall = recValid && !rdy;
            prevData  = recData;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic setAll(input logic [6:0] at, input logic [6:0] ao, input logic [6:0] it,
                          input logic [6:0] io, input logic [7:0] r, input logic l);
        aT = at; aO = ao; iT = it; iO = io; raw = r; led = l;
    endtask

    function automatic logic [6:0] pickSeg();
        if ($urandom_range(0, 9) == 0) return 7'($urandom);
        return glyph[$urandom_range(0, 15)];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    int base;

    initial begin
        // Reset with arbitrary inputs
        setAll(7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom), 8'($urandom), 1'($urandom));
        rdy = 1'($urandom);
        tick(5);
        check("rst_valid", 32'(recValid), 0);
        check("rst_level", 32'(level), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_drops", 32'(dropCount), 0);
        check("rst_data_direct", 32'(recData), 0);

        // Release with all-zero digits: one record S+2 edges later
        setAll(7'h40, 7'h40, 7'h40, 7'h40, 8'h00, 1'b0);
        rdy   = 0;
        Reset = 1;
        repeat (S + 1) @(posedge clk);
        @(negedge clk);
        check("first_early", 32'(recValid), 0);
        @(posedge clk);
        @(negedge clk);
        check("first_valid", 32'(recValid), 1);
        check("first_data", 32'(recData), 32'h0);
        check("first_level", 32'(level), 1);
        @(posedge clk);
        #1;
        rdy = 1;
        tick(S + 6);
        check("first_single", 32'(popCount), 1);
        rdy = 0;

        // Address "12", inst "3A"
        setAll(7'h79, 7'h24, 7'h30, 7'h08, 8'h5C, 1'b1);
        tick(S + 3);
        check("step_level", 32'(level), 1);
        check("step_data", 32'(recData), 32'h15C123A);
        rdy = 1; tick(3); rdy = 0;

        // Glitching AddressOnes: only the settled value is recorded
        base = popCount;
        for (int k = 0; k < 5; k++) begin
            aO = (k % 2 == 0) ? 7'h19 : 7'h12;
            tick(2);
        end
        tick(S + 2);
        check("toggle_level", 32'(level), 1);
        check("toggle_data", 32'(recData), 32'h15C143A);
        rdy = 1; tick(3); rdy = 0;
        check("toggle_single", 32'(popCount - base), 1);

        // Blank digit is an error with nibble 0
        iT = 7'h7F;
        tick(S + 3);
        check("blank_data", 32'(recData), 32'h35C140A);
        rdy = 1; tick(3); rdy = 0;

        // Fill past capacity with distinct values
        for (int i = 0; i < DEPTH + 3; i++) begin
            raw = 8'h80 + 8'(i);
            tick(S + 2);
        end
        check("full_level", 32'(level), DEPTH);
        check("full_overflow", 32'(overflow), 1);
        check("full_drops", 32'(dropCount), 3);

        // Push and pop on the same edge while full
        raw = 8'hA0;
        tick(S + 1);
        rdy = 1; tick(1); rdy = 0;
        check("pushpop_level", 32'(level), DEPTH);
        check("pushpop_drops", 32'(dropCount), 3);
        rdy = 1; tick(DEPTH + 4); rdy = 0;
        check("drained_level", 32'(level), 0);

        // Randomized traffic with random backpressure
        for (int n = 0; n < 250; n++) begin
            int hold;
            setAll(pickSeg(), pickSeg(), pickSeg(), pickSeg(), 8'($urandom_range(0, 3)), 1'($urandom));
            hold = $urandom_range(1, S + 4);
            for (int c = 0; c < hold; c++) begin
                rdy = ($urandom_range(0, 3) != 0);
                tick(1);
            end
        end

        // Queue three records, then reset asynchronously
        setAll(7'h78, 7'h78, 7'h78, 7'h78, 8'hEE, 1'b0);
        rdy = 1;
        tick(S + DEPTH + 6);
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            raw = 8'h10 + 8'(i);
            tick(S + 2);
        end
        check("queued_level", 32'(level), 3);
        Reset = 0;
        #1;
        check("async_valid", 32'(recValid), 0);
        check("async_level", 32'(level), 0);
        tick(3);
        Reset = 1;
        tick(S + 3);
        rdy = 1;
        tick(5);
        check("scoreboard_empty", 32'(sbq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
